// File: rtl/uartrx_simple.sv
// rtl/uartrx_simple.sv - minimal 8N1 UART receiver with debug state outputs
//
// Oversamples an asynchronous idle-high serial line with clk. Each frame is
// armed by a falling edge, qualified at the start-bit centre, and its eight
// data bits are sampled at their centres, LSB first. The completed byte is
// held on dout until the next good frame.
//
// Optional build macro: UARTRX_STOP_CHECK_EN
//   When defined, the stop bit is sampled one bit period after bit 7 and the
//   byte is loaded into dout only when the stop bit is 1.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   CTR_W         baud counter width, 2**CTR_W > CLKS_PER_BIT
//
// Ports:
//   clk             system clock, rising edge
//   nrst            asynchronous active-low reset
//   en              receiver enable; low forces IDLE and clears counters
//   rx              asynchronous serial input, idle high
//   dout            last completely received byte
//   out_state       0 = IDLE, 1 = RECEIVE
//   out_sample_ctr  index of the next data bit to be sampled
module uartrx_simple #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CTR_W        = 14
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       out_state,
  output logic [2:0] out_sample_ctr
);

  // RECEIVE is split internally into start-check, data and stop phases;
  // only IDLE versus not-IDLE is exported.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic             rx_m, rx_s, rx_s_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             fall;
  logic [7:0]       shifted;

  // Two-flop synchronizer plus one history flop for edge detection; all
  // reset high so that reset itself never looks like a start edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  // Only a high-to-low transition arms a frame, so a line that stays low
  // after a zero bit 7 cannot retrigger reception.
  assign fall    = rx_s_d & ~rx_s;
  assign shifted = {rx_s, shift_q[7:1]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;

    if (!en) begin
      state_d = S_IDLE;
      ctr_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ctr_d = '0;
          idx_d = 3'd0;
          if (fall) begin
            state_d = S_START;
          end
        end
        S_START: begin
          if (ctr_q == HALF_M1) begin
            ctr_d = '0;
            // High at the start-bit centre means the edge was a glitch.
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        S_DATA: begin
          if (ctr_q == FULL_M1) begin
            ctr_d   = '0;
            shift_d = shifted;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UARTRX_STOP_CHECK_EN
              state_d = S_STOP;
`else
              dout_d  = shifted;
              state_d = S_IDLE;
`endif
            end
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        S_STOP: begin
          if (ctr_q == FULL_M1) begin
            ctr_d   = '0;
            state_d = S_IDLE;
            if (rx_s) begin
              dout_d = shift_q;
            end
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          ctr_d   = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  assign dout           = dout_q;
  assign out_state      = (state_q != S_IDLE);
  assign out_sample_ctr = idx_q;

endmodule

// File: tb/tb_uartrx_simple.sv
// tb/tb_uartrx_simple.sv - self-checking bench for uartrx_simple
module tb_uartrx_simple;

  localparam int CPB = 16;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       en   = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] dout;
  logic       out_state;
  logic [2:0] out_sample_ctr;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_dout  = 8'h00;

  always #5 clk = ~clk;

  uartrx_simple #(.CLKS_PER_BIT(CPB), .CTR_W(5)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .rx             (rx),
    .dout           (dout),
    .out_state      (out_state),
    .out_sample_ctr (out_sample_ctr)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line level during bit slot i of a frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i, input logic stop);
    if (i == 0) return 1'b0;
    if (i == 9) return stop;
    return logic'((b >> (i - 1)) & 8'h01);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rx = frame_bit(b, i, stop);
      wait_clks(CPB);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; en = 1'b1; rx = 1'b1;
    wait_clks(2);
    total_cnt++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else pass_cnt++;
    total_cnt++;
    if (out_state !== 1'b0) $display("FAIL reset_state: got %b want 0", out_state); else pass_cnt++;
    total_cnt++;
    if (out_sample_ctr !== 3'd0) $display("FAIL reset_ctr: got %0d want 0", out_sample_ctr); else pass_cnt++;
    nrst = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_idle;
    rx = 1'b1; en = 1'b1;
    for (int c = 0; c < 5 * CPB; c++) begin
      wait_clks(1);
      total_cnt++;
      if ({out_state, out_sample_ctr, dout} !== {1'b0, 3'd0, exp_dout})
        $display("FAIL idle_hold: got state=%b ctr=%0d dout=%h want 0/0/%h",
                 out_state, out_sample_ctr, dout, exp_dout);
      else pass_cnt++;
    end
  endtask

  task automatic test_disabled;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = frame_bit(8'h45, i, 1'b1);
      for (int c = 0; c < CPB; c++) begin
        wait_clks(1);
        total_cnt++;
        if (out_state !== 1'b0) $display("FAIL disabled_state: got %b want 0", out_state); else pass_cnt++;
      end
    end
    total_cnt++;
    if (dout !== exp_dout) $display("FAIL disabled_dout: got %h want %h", dout, exp_dout); else pass_cnt++;
    en = 1'b1; rx = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_frame;
    logic [7:0] old;
    old = exp_dout;
    for (int i = 0; i < 10; i++) begin
      rx = frame_bit(8'h45, i, 1'b1);
      wait_clks(4);
      if (i >= 1 && i <= 8) begin
        total_cnt++;
        if (out_state !== 1'b1) $display("FAIL frame_state bit%0d: got %b want 1", i - 1, out_state); else pass_cnt++;
        total_cnt++;
        if (out_sample_ctr !== 3'(i - 1))
          $display("FAIL frame_ctr bit%0d: got %0d want %0d", i - 1, out_sample_ctr, i - 1);
        else pass_cnt++;
      end
      if (i == 8) begin
        total_cnt++;
        if (dout !== old) $display("FAIL frame_early_dout: got %h want %h", dout, old); else pass_cnt++;
      end
      wait_clks(CPB - 4);
    end
    exp_dout = 8'h45;
    wait_clks(2);
    total_cnt++;
    if (dout !== exp_dout) $display("FAIL frame_dout: got %h want %h", dout, exp_dout); else pass_cnt++;
    total_cnt++;
    if (out_state !== 1'b0) $display("FAIL frame_end_state: got %b want 0", out_state); else pass_cnt++;
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    total_cnt++;
    if (out_state !== 1'b1) $display("FAIL glitch_armed: got %b want 1", out_state); else pass_cnt++;
    wait_clks(CPB);
    total_cnt++;
    if (out_state !== 1'b0) $display("FAIL glitch_abort: got %b want 0", out_state); else pass_cnt++;
    total_cnt++;
    if (dout !== exp_dout) $display("FAIL glitch_dout: got %h want %h", dout, exp_dout); else pass_cnt++;
    wait_clks(CPB);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [2];
    bytes[0] = 8'h45;
    bytes[1] = 8'hA3;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        rx = frame_bit(bytes[f], i, 1'b1);
        wait_clks(4);
        if (i >= 1 && i <= 8) begin
          total_cnt++;
          if (out_sample_ctr !== 3'(i - 1))
            $display("FAIL b2b_ctr f%0d bit%0d: got %0d want %0d", f, i - 1, out_sample_ctr, i - 1);
          else pass_cnt++;
        end
        if (i == 9) begin
          total_cnt++;
          if (out_sample_ctr !== 3'd0) $display("FAIL b2b_wrap f%0d: got %0d want 0", f, out_sample_ctr); else pass_cnt++;
        end
        wait_clks(CPB - 4);
      end
      exp_dout = bytes[f];
      total_cnt++;
      if (dout !== exp_dout) $display("FAIL b2b_dout f%0d: got %h want %h", f, dout, exp_dout); else pass_cnt++;
    end
    rx = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_en_abort;
    for (int i = 0; i < 10; i++) begin
      rx = frame_bit(8'h5C, i, 1'b1);
      wait_clks(4);
      if (i == 5) begin
        en = 1'b0;
        wait_clks(1);
        total_cnt++;
        if ({out_state, out_sample_ctr} !== 4'h0)
          $display("FAIL abort_state: got state=%b ctr=%0d want 0/0", out_state, out_sample_ctr);
        else pass_cnt++;
        wait_clks(CPB - 5);
      end else begin
        wait_clks(CPB - 4);
      end
    end
    total_cnt++;
    if (dout !== exp_dout) $display("FAIL abort_dout: got %h want %h", dout, exp_dout); else pass_cnt++;
    rx = 1'b1; en = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 4; i++) begin
      rx = frame_bit(8'h5A, i, 1'b1);
      wait_clks(CPB);
    end
    rx = frame_bit(8'h5A, 4, 1'b1);
    wait_clks(4);
    nrst = 1'b0;
    rx = 1'b1;
    #1;
    exp_dout = 8'h00;
    total_cnt++;
    if ({out_state, out_sample_ctr, dout} !== 12'h000)
      $display("FAIL midreset_outputs: got state=%b ctr=%0d dout=%h want all 0", out_state, out_sample_ctr, dout);
    else pass_cnt++;
    wait_clks(2);
    nrst = 1'b1;
    wait_clks(2 * CPB);
    send_frame(8'h3C, 1'b1);
    exp_dout = 8'h3C;
    wait_clks(2);
    total_cnt++;
    if (dout !== exp_dout) $display("FAIL midreset_next: got %h want %h", dout, exp_dout); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic       stop, abort;
    int         abort_bit, gap;
    for (int f = 0; f < 24; f++) begin
      b         = 8'($urandom);
      gap       = $urandom_range(2, 20);
      abort     = ($urandom_range(0, 4) == 0);
      abort_bit = $urandom_range(1, 8);
      stop      = 1'b1;
`ifdef UARTRX_STOP_CHECK_EN
      stop = ($urandom_range(0, 3) != 0);
`endif
      for (int i = 0; i < 10; i++) begin
        rx = frame_bit(b, i, stop);
        wait_clks(4);
        if (abort && i == abort_bit) en = 1'b0;
        wait_clks(CPB - 4);
      end
      if (!abort && stop) exp_dout = b;
      total_cnt++;
      if (dout !== exp_dout)
        $display("FAIL random_dout f%0d: got %h want %h (sent %h abort=%b stop=%b)",
                 f, dout, exp_dout, b, abort, stop);
      else pass_cnt++;
      rx = 1'b1;
      en = 1'b1;
      wait_clks(gap);
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_disabled;
    test_frame;
    test_glitch;
    test_back_to_back;
    test_en_abort;
    test_reset_mid_frame;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
